// File: rtl/proc_fetch_seq.sv
// Instruction fetch sequencer: fetches words from a synchronous program memory, pulses Run and waits for Done.
// Optional watchdog (Done timeout -> Err, HALTED) is built when SEQ_WATCHDOG_EN is defined.
module proc_fetch_seq #(
  parameter int AW         = 5,
  parameter int START_ADDR = 0
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Stop,
  output logic [AW-1:0] MemAddr,
  output logic          MemRd,
  input  logic [8:0]    MemQ,
  output logic [8:0]    DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Err
);

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_F_INS, S_W_INS, S_F_IMM, S_W_IMM, S_ISSUE, S_EXEC, S_HALTED
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] pc_d;
  logic [8:0]    ins_q, ins_d;
  logic [8:0]    imm_q, imm_d;
  logic          stop_q, stop_d;
  logic          stop_now;

`ifdef SEQ_WATCHDOG_EN
  logic [2:0]    wd_q, wd_d;
  logic          err_q, err_d;
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d  = state;
    pc_d     = PC;
    ins_d    = ins_q;
    imm_d    = imm_q;
    stop_d   = stop_q;
    stop_now = stop_q | Stop;
`ifdef SEQ_WATCHDOG_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    if (state != S_IDLE && state != S_HALTED && Stop) stop_d = 1'b1;

    case (state)
      S_IDLE:  if (Start && !Stop) state_d = S_F_INS;
      S_F_INS: state_d = S_W_INS;
      S_W_INS: begin
        ins_d = MemQ;
        if (MemQ[8:6] == OP_MVI) begin
          state_d = S_F_IMM;
        end else if (MemQ[8:6] == OP_HALT) begin
          pc_d    = PC + AW'(1);
          state_d = S_HALTED;
        end else if (MemQ[8]) begin
          // NOPs are an instruction boundary, so a pending stop is honoured here too
          pc_d    = PC + AW'(1);
          state_d = stop_now ? S_IDLE : S_F_INS;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_F_IMM: state_d = S_W_IMM;
      S_W_IMM: begin
        imm_d   = MemQ;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_EXEC;
`ifdef SEQ_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_EXEC: begin
        if (Done) begin
          pc_d    = PC + ((ins_q[8:6] == OP_MVI) ? AW'(2) : AW'(1));
          state_d = stop_now ? S_IDLE : S_F_INS;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_q == 3'd3) begin
          err_d   = 1'b1;
          state_d = S_HALTED;
        end else begin
          wd_d    = wd_q + 3'd1;
        end
`endif
      end
      S_HALTED: begin
        if (Start) begin
          state_d = S_F_INS;
`ifdef SEQ_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_d = 1'b0;
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge Clock) begin
    // NOTE: reset is sampled synchronously and all state uses non-blocking assignments.
    if (!Resetn) begin
      state   <= S_IDLE;
      PC      <= AW'(START_ADDR);
      MemAddr <= AW'(START_ADDR);
      MemRd   <= 1'b0;
      ins_q   <= '0;
      imm_q   <= '0;
      stop_q  <= 1'b0;
      DIN     <= '0;
      Run     <= 1'b0;
      Busy    <= 1'b0;
      Halted  <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      PC      <= pc_d;
      ins_q   <= ins_d;
      imm_q   <= imm_d;
      stop_q  <= stop_d;
      MemRd   <= (state_d == S_F_INS) || (state_d == S_F_IMM);
      MemAddr <= (state_d == S_F_IMM) ? pc_d + AW'(1) : pc_d;
      DIN     <= (state_d == S_EXEC && ins_d[8:6] == OP_MVI) ? imm_d : ins_d;
      Run     <= (state_d == S_ISSUE);
      Busy    <= (state_d != S_IDLE) && (state_d != S_HALTED);
      Halted  <= (state_d == S_HALTED);
`ifdef SEQ_WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_proc_fetch_seq.sv
// Scoreboard bench for proc_fetch_seq: a program-level reference model predicts Run/immediate/halt/idle events.
module tb_proc_fetch_seq;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start = 1'b0, Stop = 1'b0;
  logic [4:0] MemAddr, PC;
  logic       MemRd, Run, Done, Busy, Halted, Err;
  logic [8:0] MemQ = '0, DIN;

  logic       Start2 = 1'b0;
  logic [1:0] MemAddr2, PC2;
  logic       MemRd2, Run2, Busy2, Halted2, Err2;
  logic [8:0] MemQ2 = '0, DIN2;
  logic       run2_q = 1'b0;

  always #5 Clock = ~Clock;

  proc_fetch_seq dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .MemAddr(MemAddr), .MemRd(MemRd), .MemQ(MemQ), .DIN(DIN), .Run(Run), .Done(Done),
    .PC(PC), .Busy(Busy), .Halted(Halted), .Err(Err)
  );

  proc_fetch_seq #(.AW(2), .START_ADDR(3)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start2), .Stop(1'b0),
    .MemAddr(MemAddr2), .MemRd(MemRd2), .MemQ(MemQ2), .DIN(DIN2), .Run(Run2), .Done(run2_q),
    .PC(PC2), .Busy(Busy2), .Halted(Halted2), .Err(Err2)
  );

  // Program memories (synchronous read)
  logic [8:0] mem [32];
  logic [8:0] mem2 [4];
  always @(posedge Clock) if (MemRd) MemQ <= mem[MemAddr];
  always @(posedge Clock) if (MemRd2) MemQ2 <= mem2[MemAddr2];
  always @(posedge Clock) run2_q <= Run2;

  // Processor stand-in: IR latched on Run, Done after the opcode's Tstep count plus a random stall.
  int         extra [256];
  logic [8:0] p_r [8];
  logic [8:0] p_ir;
  logic       p_busy, p_kill = 1'b0;
  int         p_t, p_need, p_idx;
  assign Done = p_busy && !p_kill && (p_t == p_need);

  always @(posedge Clock) begin
    if (!Resetn) begin
      p_busy <= 1'b0; p_t <= 0; p_need <= 0; p_idx <= 0; p_ir <= '0;
      for (int i = 0; i < 8; i++) p_r[i] <= '0;
    end else if (Run) begin
      p_busy <= 1'b1;
      p_t    <= 1;
      p_ir   <= DIN;
      p_need <= ((DIN[8:6] == 3'b010 || DIN[8:6] == 3'b011) ? 3 : 1) + extra[p_idx % 256];
      p_idx  <= p_idx + 1;
    end else if (Done) begin
      p_busy <= 1'b0;
      case (p_ir[8:6])
        3'b000:  p_r[p_ir[5:3]] <= p_r[p_ir[2:0]];
        3'b001:  p_r[p_ir[5:3]] <= DIN;
        3'b010:  p_r[p_ir[5:3]] <= p_r[p_ir[5:3]] + p_r[p_ir[2:0]];
        3'b011:  p_r[p_ir[5:3]] <= p_r[p_ir[5:3]] - p_r[p_ir[2:0]];
        default: ;
      endcase
    end else if (p_busy) begin
      p_t <= p_t + 1;
    end
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: walks the program with the documented per-class cycle counts
  typedef enum int {EV_RUN, EV_IMM, EV_HALT, EV_IDLE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       pc;
    int       din;
    int       t;
  } ev_t;
  ev_t        exp_q [$];
  logic [8:0] m_r [8];
  int         m_pc, m_idx;

  task automatic push_ev(input ev_kind_t k, input int pc, input int din, input int t);
    ev_t e;
    e.kind = k; e.pc = pc; e.din = din; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic model_walk(input int stop_after);
    int t = 0, issues = 0, pc = m_pc, x, y;
    logic [8:0] w;
    for (int g = 0; g < 200; g++) begin
      w = mem[pc]; x = int'(w[5:3]); y = int'(w[2:0]);
      if (w[8:6] == 3'b111) begin
        m_pc = (pc + 1) % 32;
        push_ev(EV_HALT, m_pc, 0, t + 2);
        return;
      end else if (w[8]) begin
        pc = (pc + 1) % 32; t += 2;
        continue;
      end else if (w[8:6] == 3'b001) begin
        push_ev(EV_RUN, pc, int'(w), t + 4);
        push_ev(EV_IMM, pc, int'(mem[(pc + 1) % 32]), t + 5);
        m_r[x] = mem[(pc + 1) % 32];
        t += 6 + extra[m_idx % 256];
        pc = (pc + 2) % 32;
      end else begin
        push_ev(EV_RUN, pc, int'(w), t + 2);
        case (w[8:6])
          3'b000:  begin m_r[x] = m_r[y];          t += 4 + extra[m_idx % 256]; end
          3'b010:  begin m_r[x] = m_r[x] + m_r[y]; t += 6 + extra[m_idx % 256]; end
          default: begin m_r[x] = m_r[x] - m_r[y]; t += 6 + extra[m_idx % 256]; end
        endcase
        pc = (pc + 1) % 32;
      end
      m_idx++; issues++;
      if (issues == stop_after) begin
        m_pc = pc;
        push_ev(EV_IDLE, pc, 0, t);
        return;
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows Run, an mvi EXEC cycle, HALTED or IDLE entry
  logic sb_en = 1'b0;
  int   base = 0, total_runs = 0;
  initial begin
    logic pb = 1'b0, ph = 1'b0, imm_due = 1'b0;
    int   rel;
    ev_t  e;
    forever begin
      @(negedge Clock);
      if (sb_en && Resetn) begin
        rel = cyc - base;
        if (imm_due) begin
          imm_due = 1'b0;
          if (exp_q.size() == 0) check("imm_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("imm_kind", int'(e.kind), int'(EV_IMM));
            check("imm_din", int'(DIN), e.din);
            check("imm_time", rel, e.t);
          end
        end
        if (Run) begin
          total_runs++;
          if (exp_q.size() == 0) check("run_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("run_kind", int'(e.kind), int'(EV_RUN));
            check("run_din", int'(DIN), e.din);
            check("run_pc", int'(PC), e.pc);
            check("run_time", rel, e.t);
            imm_due = (((e.din >> 6) & 7) == 1);
          end
        end
        if ((Halted && !ph) || (pb && !Busy && !Halted)) begin
          if (exp_q.size() == 0) check("stop_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("end_kind", int'(e.kind), Halted ? int'(EV_HALT) : int'(EV_IDLE));
            check("end_pc", int'(PC), e.pc);
            check("end_time", rel, e.t);
          end
        end
      end
      pb = Busy; ph = Halted;
    end
  end

  task automatic do_reset();
    sb_en = 1'b0;
    Resetn = 1'b0;
    exp_q.delete();
    m_pc = 0; m_idx = 0; total_runs = 0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    for (int i = 0; i < 256; i++) extra[i] = int'($urandom_range(0, 1));
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    sb_en = 1'b1;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 32; i++) mem[i] = 9'b111_000_000;
  endtask

  task automatic run_prog(input int stop_after);
    int  runs = 0;
    bit  finished = 0;
    model_walk(stop_after);
    @(negedge Clock); Start = 1'b1; base = cyc + 1;
    @(negedge Clock); Start = 1'b0;
    for (int i = 0; i < 400 && !finished; i++) begin
      if (Run) runs++;
      Stop = (stop_after > 0 && Run && runs == stop_after);
      if (!Busy) finished = 1;
      else @(negedge Clock);
    end
    if (!finished) check("timeout", 0, 1);
    Stop = 1'b0;
    @(negedge Clock);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) check({tag, "_reg"}, int'(p_r[i]), int'(m_r[i]));
  endtask

  initial begin
    int   n_rd, rd1, run_din, exec_din, rel;
    bit   exec_next;
    logic [2:0] op;

    // Reset state
    fill_halt();
    do_reset();
    @(negedge Clock);
    check("rst_pc", int'(PC), 0);
    check("rst_memaddr", int'(MemAddr), 0);
    check("rst_din", int'(DIN), 0);
    check("rst_run", int'(Run), 0);
    check("rst_memrd", int'(MemRd), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_halted", int'(Halted), 0);
    check("rst_err", int'(Err), 0);
    check("rst_pc2", int'(PC2), 3);

    // Start together with Stop in IDLE stays IDLE
    Start = 1'b1; Stop = 1'b1;
    @(negedge Clock);
    Start = 1'b0; Stop = 1'b0;
    check("startstop_busy", int'(Busy), 0);
    check("startstop_memrd", int'(MemRd), 0);

    // mvi R1,5 ; HALT
    mem[0] = 9'b001_001_000; mem[1] = 9'd5; mem[2] = 9'b111_000_000;
    run_prog(0);
    check("t1_r1", int'(p_r[1]), 5);
    check("t1_pc", int'(PC), 3);
    check("t1_halted", int'(Halted), 1);
    check("t1_runs", total_runs, 1);
    // Restart from HALTED at the current PC (another HALT)
    run_prog(0);
    check("t1_restart_pc", int'(PC), 4);

    // mvi R0,3 ; mvi R1,4 ; add R0,R1 ; sub R0,R1 ; HALT
    for (int pass = 0; pass < 2; pass++) begin
      fill_halt();
      do_reset();
      mem[0] = 9'b001_000_000; mem[1] = 9'd3;
      mem[2] = 9'b001_001_000; mem[3] = 9'd4;
      mem[4] = 9'b010_000_001; mem[5] = 9'b011_000_001;
      if (pass == 1) begin
        run_prog(3);
        check("stop_busy", int'(Busy), 0);
        check("stop_halted", int'(Halted), 0);
        check("stop_pc", int'(PC), 5);
        check("stop_r0", int'(p_r[0]), 7);
      end
      run_prog(0);
      check("t2_r0", int'(p_r[0]), 3);
      check("t2_runs", total_runs, 4);
      check("t2_pc", int'(PC), 7);
    end

    // NOP at 0, mv R3,R1 at 1
    fill_halt();
    do_reset();
    mem[0] = 9'b100_010_011; mem[1] = 9'b000_011_001;
    run_prog(0);
    check("nop_runs", total_runs, 1);
    check("nop_pc", int'(PC), 3);

    // Randomized programs, optionally stopped after a random issue count and resumed
    for (int k = 0; k < 20; k++) begin
      do_reset();
      for (int a = 0; a < 30; a++) begin
        op = 3'($urandom_range(0, 7));
        if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'b000;
        mem[a] = {op, 6'($urandom())};
      end
      mem[30] = 9'b111_000_000; mem[31] = 9'b111_000_000;
      run_prog(int'($urandom_range(0, 3)));
      if (!Halted) run_prog(0);
      check("rand_halted", int'(Halted), 1);
      check("rand_pc", int'(PC), m_pc);
      check("rand_err", int'(Err), 0);
      check_regs("rand");
    end

`ifdef SEQ_WATCHDOG_EN
    // Done never arrives: Err and HALTED after four EXEC cycles, PC unchanged
    fill_halt();
    do_reset();
    sb_en = 1'b0;
    mem[0] = 9'b000_001_010;
    p_kill = 1'b1;
    @(negedge Clock); Start = 1'b1; base = cyc + 1;
    @(negedge Clock); Start = 1'b0;
    for (int i = 0; i < 30 && !Halted; i++) @(negedge Clock);
    rel = cyc - base;
    check("wd_halted", int'(Halted), 1);
    check("wd_err", int'(Err), 1);
    check("wd_pc", int'(PC), 0);
    check("wd_time", rel, 7);
    p_kill = 1'b0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check("wd_err_clear", int'(Err), 0);
    check("wd_restart_busy", int'(Busy), 1);
`endif

    // AW=2, START_ADDR=3: mvi at the top address wraps to 0 for its immediate
    do_reset();
    sb_en = 1'b0;
    mem2[3] = 9'b001_010_000; mem2[0] = 9'd77; mem2[1] = 9'b111_000_000; mem2[2] = 9'd0;
    n_rd = 0; rd1 = -1; run_din = -1; exec_din = -1; exec_next = 0;
    @(negedge Clock); Start2 = 1'b1;
    @(negedge Clock); Start2 = 1'b0;
    for (int i = 0; i < 30 && !Halted2; i++) begin
      if (MemRd2) begin
        if (n_rd == 1) rd1 = int'(MemAddr2);
        n_rd++;
      end
      if (exec_next) begin exec_din = int'(DIN2); exec_next = 0; end
      if (Run2) begin run_din = int'(DIN2); exec_next = 1; end
      @(negedge Clock);
    end
    check("wrap_reads", n_rd, 3);
    check("wrap_imm_addr", rd1, 0);
    check("wrap_run_din", run_din, 9'b001_010_000);
    check("wrap_exec_din", exec_din, 77);
    check("wrap_halted", int'(Halted2), 1);
    check("wrap_pc", int'(PC2), 2);
    check("wrap_busy", int'(Busy2), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
